mem_access_arbiter: RTL
=======================

// Module: mem_access_arbiter
// PURPOSE
//  Shares the 4x8 store-strobed memory_system between two requesters (A, B).
//  Round-robin arbitration; sequences each access as setup/strobe/hold so
//  addr/data are stable around the level-sensitive store pulse. Sits between
//  switch/button front-end logic and memory_system in top.
// PARAMETERS
//  DATA_W        8  word width (matches memory_system data)
//  ADDR_W        2  address width (4 words)
//  STROBE_CYCLES 1  cycles mem_store held high per write (1..15)
// PORTS
//  clk         in   1       system clock, all state on rising edge
//  reset       in   1       synchronous, active-high
//  a_req       in   1       A request; hold with fields stable until a_ack
//  a_we        in   1       A: 1=write, 0=read
//  a_addr      in   ADDR_W  A word address
//  a_wdata     in   DATA_W  A write data
//  a_ack       out  1       A one-cycle completion pulse
//  b_req/b_we/b_addr/b_wdata/b_ack   same as A, requester B
//  rdata       out  DATA_W  read result; valid with ack, held until next read ack
//  busy        out  1       1 whenever FSM not in IDLE
//  mem_addr    out  ADDR_W  to memory_system.addr
//  mem_data    out  DATA_W  to memory_system.data
//  mem_store   out  1       to memory_system.store
//  mem_rdata   in   DATA_W  from memory_system.memory (word at mem_addr)
//  a_grants    out  8       A grant count (see CONFIGURATION)
//  b_grants    out  8       B grant count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, rr pointer favours A, counters 0.
//    Reset mid-access aborts it: mem_store low next edge, no ack issued.
//  - FSM: IDLE -> SETUP -> (write) STROBE x STROBE_CYCLES -> HOLD -> DONE
//                          (read)  SAMPLE -> DONE;  DONE -> IDLE always.
//  - IDLE: if any req, latch winner's we/addr/wdata, record winner, go SETUP.
//  - Arbitration: one req -> it wins. Both -> the one NOT granted last wins;
//    after reset A wins first tie. Pointer updates on grant only.
//  - SETUP: mem_addr/mem_data driven from latched fields, mem_store=0.
//  - STROBE: mem_store=1; addr/data unchanged. HOLD: mem_store=0, unchanged.
//  - SAMPLE: rdata <= mem_rdata at end of cycle.
//  - DONE: winner's ack=1 for exactly one cycle; other ack stays 0.
//  - Latency (req seen in IDLE at cycle 0): write ack cycle 3+STROBE_CYCLES,
//    read ack cycle 3. Min one IDLE cycle between accesses.
//  - mem_addr/mem_data hold last values in IDLE (no glitch to memory).
//  - Req dropped before ack: access still completes and ack pulses.
//  - Request arriving while busy waits; not lost while req held high.
//  - rdata unchanged by writes.
// CONFIGURATION
//  MEM_ARB_STATS_EN defined: a_grants/b_grants count grants per requester,
//    saturate at 255, cleared by reset.
//  Undefined: a_grants/b_grants tied to 0, no counter logic.
// STRUCTURE
//  mem_arb_pkg: FSM state encoding (IDLE,SETUP,STROBE,SAMPLE,HOLD,DONE),
//    DATA_W/ADDR_W defaults, requester ID constants (REQ_A=0, REQ_B=1).
//  Sub-module rr_arbiter2: 2-way round-robin pick + last-grant pointer.
// TESTING
//  1 A write addr=2 data=0xA5 -> SETUP, store high 1 cycle, HOLD, a_ack at
//    cycle 4; mem_addr=2, mem_data=0xA5 stable from cycle 1 to 3.
//  2 B read addr=2 after test 1 (mem model) -> b_ack cycle 3, rdata=0xA5.
//  3 a_req,b_req both high from reset, held -> grants A,B,A,B; acks alternate.
//  4 STROBE_CYCLES=3 write -> mem_store high exactly 3 cycles, ack cycle 6.
//  5 reset asserted during STROBE -> next edge store=0, busy=0, no ack,
//    outputs 0; subsequent A write completes normally.
//  6 MEM_ARB_STATS_EN: 300 A grants -> a_grants=255; undefined -> both 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared definitions for the memory access arbiter:
//   - arb_state_t : access sequencer states.
//   - DEF_DATA_W / DEF_ADDR_W : default word and address widths
//     (these match the 4x8 memory_system).
//   - REQ_A / REQ_B : requester identifiers used by the arbiter and
//     the round-robin pointer.
package mem_arb_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 2;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    SAMPLE = 3'd3,
    HOLD   = 3'd4,
    DONE   = 3'd5
  } arb_state_t;

endpackage

// File: rtl/mem_access_arbiter_if.sv
// mem_access_arbiter_if
//   Bundles the two requester handshakes and the memory_system bus.
//   Modports:
//     slave  : arbiter side (consumes requests, drives acks, rdata,
//              busy and the memory address/data/store lines)
//     master : requester/memory side (drives requests and mem_rdata)
//   Signals:
//     a_req/a_we/a_addr/a_wdata, a_ack : requester A handshake
//     b_req/b_we/b_addr/b_wdata, b_ack : requester B handshake
//     rdata, busy                      : read result, sequencer activity
//     mem_addr/mem_data/mem_store      : to memory_system
//     mem_rdata                        : word at mem_addr from memory_system
interface mem_access_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);

  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_ack;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ack;

  logic [DATA_W-1:0] rdata;
  logic              busy;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_store;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    output a_ack, b_ack, rdata, busy,
    output mem_addr, mem_data, mem_store,
    input  mem_rdata
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    input  a_ack, b_ack, rdata, busy,
    input  mem_addr, mem_data, mem_store,
    output mem_rdata
  );

endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
//   Two-way round-robin pick with a last-grant pointer.
//   Ports:
//     clk, reset : clock, synchronous active-high reset
//     req_a/b    : request lines
//     grant_en   : a grant is being taken this cycle (pointer updates)
//     gnt_valid  : at least one request present
//     gnt_id     : winning requester (REQ_A / REQ_B)
//   On a tie the requester not granted last wins; after reset the
//   pointer reads "B granted last" so A takes the first tie.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_a,
  input  logic req_b,
  input  logic grant_en,
  output logic gnt_valid,
  output logic gnt_id
);

  logic last_id;

  always_comb begin
    gnt_valid = req_a | req_b;
    gnt_id    = REQ_A;
    if (req_a && req_b) begin
      gnt_id = (last_id == REQ_A) ? REQ_B : REQ_A;
    end else if (req_b) begin
      gnt_id = REQ_B;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_id <= REQ_B;
    end else if (grant_en && gnt_valid) begin
      last_id <= gnt_id;
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter
//   Shares the store-strobed memory_system between requesters A and B.
//   Round-robin arbitration; each access is sequenced as
//   SETUP -> STROBE x STROBE_CYCLES -> HOLD -> DONE (write) or
//   SETUP -> SAMPLE -> DONE (read), so address and data are stable
//   around the level-sensitive store pulse.
//   Ports:
//     clk, reset          : clock, synchronous active-high reset
//     bus (slave modport) : requester handshakes, rdata, busy, memory bus
//     a_grants, b_grants  : per-requester grant counts
//   Build option MEM_ARB_STATS_EN: when defined, a_grants/b_grants count
//   grants (saturating at 255, cleared by reset); otherwise both are 0.
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int STROBE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_access_arbiter_if.slave  bus,
  output logic [7:0]           a_grants,
  output logic [7:0]           b_grants
);

  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);

  arb_state_t        state, state_nxt;
  logic [3:0]        strobe_cnt;
  logic              gnt_valid;
  logic              gnt_id;
  logic              grant_take;
  logic              cur_id;
  logic              cur_we;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] data_r;
  logic [DATA_W-1:0] rdata_r;

  assign grant_take = (state == IDLE) && gnt_valid;

  rr_arbiter2 u_rr (
    .clk       (clk),
    .reset     (reset),
    .req_a     (bus.a_req),
    .req_b     (bus.b_req),
    .grant_en  (state == IDLE),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:         if (gnt_valid) state_nxt = SETUP;
      SETUP:        state_nxt = cur_we ? STROBE : SAMPLE;
      STROBE:       if (strobe_cnt == STROBE_LAST) state_nxt = HOLD;
      HOLD, SAMPLE: state_nxt = DONE;
      DONE:         state_nxt = IDLE;
      default:      state_nxt = IDLE;
    endcase
  end

  // Counts completed strobe cycles; cleared whenever not strobing.
  always_ff @(posedge clk) begin
    if (reset) begin
      strobe_cnt <= '0;
    end else if (state == STROBE) begin
      strobe_cnt <= strobe_cnt + 4'd1;
    end else begin
      strobe_cnt <= '0;
    end
  end

  // Grant stage: latch winner's fields. The memory bus is driven straight
  // from these registers, so it holds its last value through IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_id  <= REQ_A;
      cur_we  <= 1'b0;
      addr_r  <= '0;
      data_r  <= '0;
      rdata_r <= '0;
    end else begin
      if (grant_take) begin
        cur_id <= gnt_id;
        if (gnt_id == REQ_B) begin
          cur_we <= bus.b_we;
          addr_r <= bus.b_addr;
          data_r <= bus.b_wdata;
        end else begin
          cur_we <= bus.a_we;
          addr_r <= bus.a_addr;
          data_r <= bus.a_wdata;
        end
      end
      // Sample stage: capture read word; writes never touch rdata.
      if (state == SAMPLE) begin
        rdata_r <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_addr  = addr_r;
  assign bus.mem_data  = data_r;
  assign bus.mem_store = (state == STROBE);
  assign bus.busy      = (state != IDLE);
  assign bus.a_ack     = (state == DONE) && (cur_id == REQ_A);
  assign bus.b_ack     = (state == DONE) && (cur_id == REQ_B);
  assign bus.rdata     = rdata_r;

`ifdef MEM_ARB_STATS_EN
  logic [7:0] a_cnt;
  logic [7:0] b_cnt;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      a_cnt <= '0;
      b_cnt <= '0;
    end else if (grant_take) begin
      if (gnt_id == REQ_B) begin
        b_cnt <= sat_inc(b_cnt);
      end else begin
        a_cnt <= sat_inc(a_cnt);
      end
    end
  end

  assign a_grants = a_cnt;
  assign b_grants = b_cnt;
`else
  assign a_grants = '0;
  assign b_grants = '0;
`endif

endmodule
